// File: rtl/fsm_sequencer.sv
// Execution core for the state sequencer: holds the state address, evaluates one instruction per tick,
// runs the dwell counters and registers the output opcode. Optional macro: FSM_SINGLE_STEP_EN.
module fsm_sequencer #(
    parameter int STATE_COUNT   = 8,
    parameter int OUTPUT_WIDTH  = 4,
    parameter int COND_WIDTH    = 2,
    parameter int ACTION_WIDTH  = 1,
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNTER_COUNT = 2,
    parameter int IN_WIDTH      = 2,
    parameter int SLOW_DIV      = 256,
    localparam int AW = (STATE_COUNT > 1) ? $clog2(STATE_COUNT) : 1
) (
    input  logic                                   clock,
    input  logic                                   rst_n,
    input  logic                                   run,
    input  logic                                   prog_enable,
    input  logic [IN_WIDTH-1:0]                    ext_in,
    output logic [AW-1:0]                          addr,
    input  logic [AW-1:0]                          jump_target,
    input  logic                                   repeat_state,
    input  logic                                   slow_mode,
    input  logic [OUTPUT_WIDTH-1:0]                output_opcode,
    input  logic [COND_WIDTH-1:0]                  cond,
    input  logic [ACTION_WIDTH-1:0]                then_action,
    input  logic [ACTION_WIDTH-1:0]                else_action,
    input  logic [COUNTER_WIDTH*COUNTER_COUNT-1:0] const_data,
`ifdef FSM_SINGLE_STEP_EN
    input  logic                                   step_mode,
    input  logic                                   step,
`endif
    output logic [OUTPUT_WIDTH-1:0]                out_data,
    output logic                                   tick,
    output logic                                   running
);

    localparam int PW    = $clog2(SLOW_DIV);
    localparam int NSRC  = 2 ** COND_WIDTH;
    localparam int RAW_W = IN_WIDTH + COUNTER_COUNT;
    localparam logic [AW-1:0] ADDR_LAST  = AW'(STATE_COUNT - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SLOW_DIV - 1);

    typedef enum logic [0:0] {
        CTL_IDLE = 1'b0,
        CTL_RUN  = 1'b1
    } ctl_t;

    ctl_t                     ctl;
    ctl_t                     ctl_next;
    logic [PW-1:0]            presc;
    logic [COUNTER_WIDTH-1:0] ctr [COUNTER_COUNT];
    logic [COUNTER_COUNT-1:0] ctr_zero;
    logic [RAW_W-1:0]         cond_raw;
    logic [NSRC-1:0]          cond_vec;
    logic                     leave;
    logic                     ev_src;
    logic                     ev;
    logic                     cond_true;
    logic                     act;
    logic [AW-1:0]            fall_addr;
    logic [AW-1:0]            addr_ev;
    logic [AW-1:0]            addr_next;
    logic                     load_all;
    logic                     reload;
    logic                     unused_bits;

    // Only bit 0 of each action field carries meaning; the rest are accepted and ignored.
    assign unused_bits = ^{then_action, else_action, cond_raw};

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ctl <= CTL_IDLE;
        end else begin
            ctl <= ctl_next;
        end
    end

    // Leaving RUN wins over a tick in the same cycle.
    assign leave = (ctl == CTL_RUN) && (!run || prog_enable);

    always_comb begin
        ctl_next = ctl;
        case (ctl)
            CTL_IDLE: if (run && !prog_enable) ctl_next = CTL_RUN;
            CTL_RUN:  if (leave) ctl_next = CTL_IDLE;
            default:  ctl_next = CTL_IDLE;
        endcase
    end

`ifdef FSM_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step && !step_q;
    assign ev_src    = step_mode ? step_rise : (!slow_mode || (presc == PRESC_LAST));
`else
    assign ev_src = !slow_mode || (presc == PRESC_LAST);
`endif

    assign ev = (ctl == CTL_RUN) && !leave && ev_src;

    always_comb begin
        for (int k = 0; k < COUNTER_COUNT; k++) begin
            ctr_zero[k] = (ctr[k] == '0);
        end
    end

    assign cond_raw = {ext_in, ctr_zero};

    // Condition sources beyond the available inputs read as 0.
    for (genvar i = 0; i < NSRC; i++) begin : g_cond
        if (i < RAW_W) begin : g_src
            assign cond_vec[i] = cond_raw[i];
        end else begin : g_pad
            assign cond_vec[i] = 1'b0;
        end
    end

    assign cond_true = cond_vec[cond];
    assign act       = cond_true ? then_action[0] : else_action[0];
    assign fall_addr = (addr == ADDR_LAST) ? '0 : addr + AW'(1);

    always_comb begin
        addr_ev = addr;
        if (act) begin
            addr_ev = jump_target;
        end else if (!repeat_state) begin
            addr_ev = fall_addr;
        end
    end

    always_comb begin
        addr_next = addr;
        if (ctl_next == CTL_IDLE) begin
            addr_next = '0;
        end else if (ev) begin
            addr_next = addr_ev;
        end
    end

    // Counters follow const_data whenever not running, and reload on any real address change.
    assign load_all = (ctl != CTL_RUN) || leave;
    assign reload   = ev && (addr_ev != addr);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int k = 0; k < COUNTER_COUNT; k++) begin
                ctr[k] <= '0;
            end
        end else if (load_all || reload) begin
            for (int k = 0; k < COUNTER_COUNT; k++) begin
                ctr[k] <= const_data[k*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end else if (ev) begin
            for (int k = 0; k < COUNTER_COUNT; k++) begin
                if (ctr[k] != '0) ctr[k] <= ctr[k] - COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (load_all) begin
            presc <= '0;
        end else begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            addr     <= '0;
            out_data <= '0;
            tick     <= 1'b0;
            running  <= 1'b0;
        end else begin
            addr    <= addr_next;
            tick    <= ev;
            running <= (ctl_next == CTL_RUN);
            if (ctl == CTL_RUN) out_data <= output_opcode;
        end
    end

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench for fsm_sequencer: a combinational instruction-memory model feeds the DUT, and
// expected {running, tick, addr} values are queued per step and compared after each clock edge.
module tb_fsm_sequencer;

    localparam int AW  = 3;
    localparam int OW  = 4;
    localparam int CW  = 2;
    localparam int IW  = 2;
    localparam int CTW = 16;
    localparam int CC  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst_n;
    logic              run;
    logic              run6;
    logic              prog_enable;
    logic              slow_mode;
    logic [IW-1:0]     ext_in;
    logic [AW-1:0]     addr;
    logic [AW-1:0]     jump_target;
    logic              repeat_state;
    logic [OW-1:0]     output_opcode;
    logic [CW-1:0]     cond;
    logic [0:0]        then_action;
    logic [0:0]        else_action;
    logic [CTW*CC-1:0] const_data;
    logic [OW-1:0]     out_data;
    logic              tick;
    logic              running;
    logic [AW-1:0]     addr6;
    logic [OW-1:0]     out6;
    logic              tick6;
    logic              running6;
`ifdef FSM_SINGLE_STEP_EN
    logic              step_mode;
    logic              step;
`endif

    // Instruction memory model, indexed by the DUT address.
    logic [AW-1:0] m_jt   [8];
    logic          m_rep  [8];
    logic [CW-1:0] m_cond [8];
    logic          m_then [8];
    logic          m_else [8];

    assign jump_target   = m_jt[addr];
    assign repeat_state  = m_rep[addr];
    assign cond          = m_cond[addr];
    assign then_action   = m_then[addr];
    assign else_action   = m_else[addr];
    assign output_opcode = {1'b1, addr};
    assign const_data    = {16'd5, 16'd3};

    fsm_sequencer #(.SLOW_DIV(4)) dut (
        .clock(clock), .rst_n(rst_n), .run(run), .prog_enable(prog_enable), .ext_in(ext_in),
        .addr(addr), .jump_target(jump_target), .repeat_state(repeat_state), .slow_mode(slow_mode),
        .output_opcode(output_opcode), .cond(cond), .then_action(then_action),
        .else_action(else_action), .const_data(const_data),
`ifdef FSM_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .out_data(out_data), .tick(tick), .running(running)
    );

    fsm_sequencer #(.STATE_COUNT(6), .SLOW_DIV(4)) dut6 (
        .clock(clock), .rst_n(rst_n), .run(run6), .prog_enable(1'b0), .ext_in(2'b00),
        .addr(addr6), .jump_target(3'd0), .repeat_state(1'b0), .slow_mode(1'b0),
        .output_opcode(4'd0), .cond(2'd0), .then_action(1'b0), .else_action(1'b0),
        .const_data(32'd0),
`ifdef FSM_SINGLE_STEP_EN
        .step_mode(1'b0), .step(1'b0),
`endif
        .out_data(out6), .tick(tick6), .running(running6)
    );

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    function automatic logic [4:0] st(input logic r, input logic t, input logic [AW-1:0] a);
        return {r, t, a};
    endfunction

    task automatic wait_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_check(input string tag, input logic [4:0] got);
        logic [4:0] want;
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got running/tick/addr=%b expected %b", tag, got, want);
        end
    endtask

    task automatic clk_exp(input string tag, input logic [4:0] e);
        exp_q.push_back(e);
        wait_clk();
        sb_check(tag, {running, tick, addr});
    endtask

    task automatic check_out(input string tag, input logic [OW-1:0] e);
        checks++;
        assert (out_data === e) else begin
            errors++;
            $error("FAIL %s: got out_data=%0d expected %0d", tag, out_data, e);
        end
    endtask

    task automatic prog_fall();
        for (int i = 0; i < 8; i++) begin
            m_jt[i] = '0; m_rep[i] = 1'b0; m_cond[i] = '0; m_then[i] = 1'b0; m_else[i] = 1'b0;
        end
    endtask

    initial begin
        // Reset with arbitrary inputs
        prog_fall();
        rst_n       = 1'b0;
        run         = 1'($urandom_range(0, 1));
        run6        = 1'($urandom_range(0, 1));
        prog_enable = 1'($urandom_range(0, 1));
        slow_mode   = 1'($urandom_range(0, 1));
        ext_in      = 2'($urandom_range(0, 3));
`ifdef FSM_SINGLE_STEP_EN
        step_mode   = 1'($urandom_range(0, 1));
        step        = 1'($urandom_range(0, 1));
`endif
        clk_exp("reset_c1", st(0, 0, 0));
        clk_exp("reset_c2", st(0, 0, 0));
        check_out("reset_out", 4'd0);
        exp_q.push_back(st(0, 0, 0));
        sb_check("reset_dut6", {running6, tick6, addr6});

        rst_n = 1'b1; run = 1'b0; run6 = 1'b0; prog_enable = 1'b0; slow_mode = 1'b0; ext_in = 2'b00;
`ifdef FSM_SINGLE_STEP_EN
        step_mode = 1'b0; step = 1'b0;
`endif
        clk_exp("idle", st(0, 0, 0));

        // Wrap at STATE_COUNT-1 for a non-power-of-two state count
        run6 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(st(1, k > 0, 3'(k % 6)));
            wait_clk();
            sb_check("wrap6", {running6, tick6, addr6});
        end
        run6 = 1'b0;

        // Dwell on counter 0, condition jumps, external inputs and wrap 7 -> 0
        m_cond[0] = 2'd0; m_then[0] = 1'b1; m_rep[0] = 1'b1; m_jt[0] = 3'd5;
        m_cond[5] = 2'd0; m_then[5] = 1'b1; m_rep[5] = 1'b1; m_jt[5] = 3'd2;
        m_cond[2] = 2'd2; m_then[2] = 1'b1; m_rep[2] = 1'b0; m_jt[2] = 3'd6;
        m_cond[3] = 2'd3; m_then[3] = 1'b1; m_rep[3] = 1'b1; m_jt[3] = 3'd7;
        run = 1'b1;
        clk_exp("enter_run", st(1, 0, 0));
        check_out("out_hold_idle", 4'd0);
        for (int k = 0; k < 3; k++) clk_exp("dwell0", st(1, 1, 0));
        clk_exp("jump5", st(1, 1, 5));
        check_out("out_addr0", 4'd8);
        clk_exp("dwell5", st(1, 1, 5));
        check_out("out_addr5", 4'd13);
        for (int k = 0; k < 2; k++) clk_exp("dwell5", st(1, 1, 5));
        clk_exp("jump2", st(1, 1, 2));
        clk_exp("ext0_fall", st(1, 1, 3));
        for (int k = 0; k < 2; k++) clk_exp("repeat3", st(1, 1, 3));
        ext_in = 2'b10;
        clk_exp("ext1_jump7", st(1, 1, 7));
        ext_in = 2'b00;
        clk_exp("wrap7", st(1, 1, 0));
        for (int k = 0; k < 3; k++) clk_exp("reload_dwell0", st(1, 1, 0));
        clk_exp("reload_jump5", st(1, 1, 5));
        run = 1'b0;
        clk_exp("run_drop", st(0, 0, 0));

        // Slow mode: one tick every SLOW_DIV cycles
        prog_fall();
        slow_mode = 1'b1;
        run = 1'b1;
        clk_exp("slow_enter", st(1, 0, 0));
        for (int k = 1; k <= 12; k++) clk_exp("slow", st(1, (k % 4) == 0, 3'(k / 4)));

        // prog_enable with a tick due
        slow_mode = 1'b0;
        prog_enable = 1'b1;
        clk_exp("prog_abort", st(0, 0, 0));
        clk_exp("prog_hold", st(0, 0, 0));
        prog_enable = 1'b0;
        clk_exp("prog_release", st(1, 0, 0));
        clk_exp("fast_tick", st(1, 1, 1));

`ifdef FSM_SINGLE_STEP_EN
        run = 1'b0;
        clk_exp("step_idle", st(0, 0, 0));
        step_mode = 1'b1;
        run = 1'b1;
        clk_exp("step_enter", st(1, 0, 0));
        step = 1'b1;
        clk_exp("step_edge", st(1, 1, 1));
        for (int k = 0; k < 9; k++) clk_exp("step_held", st(1, 0, 1));
        step = 1'b0;
        step_mode = 1'b0;
        clk_exp("step_off", st(1, 1, 2));
        clk_exp("step_off", st(1, 1, 3));
`endif

        // Reset mid-operation
        rst_n = 1'b0;
        clk_exp("mid_reset", st(0, 0, 0));
        check_out("mid_reset_out", 4'd0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
